// File: rtl/sudoku_uart_pkg.sv
// Shared definitions for the sudoku game-state UART streamer.
// Holds the frame byte offsets, the default sync byte, the controller state
// enum and the snapshot payload struct.
// Build option STREAMER_CHECKSUM_EN appends an XOR checksum byte (index 69).
package sudoku_uart_pkg;

    localparam int unsigned IDX_W       = 7;
    localparam int unsigned HDR_IDX     = 0;
    localparam int unsigned BOARD_IDX   = 7;
    localparam int unsigned COLOR_IDX   = 48;
    localparam int unsigned BOARD_W     = 324;
    localparam int unsigned COLOR_W     = 162;
    localparam int unsigned BOARD_BYTES = 41;
    localparam int unsigned COLOR_BYTES = 21;
`ifdef STREAMER_CHECKSUM_EN
    localparam int unsigned DATA_LAST_IDX = 68;
    localparam int unsigned LAST_IDX      = 69;
`else
    localparam int unsigned LAST_IDX      = 68;
`endif

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    typedef struct packed {
        logic [2:0]         current_state;
        logic               game_dificulty;
        logic [BOARD_W-1:0] full_board;
        logic [COLOR_W-1:0] colors;
        logic [7:0]         position;
        logic [1:0]         errors;
        logic [3:0]         selected_number;
        logic               victory_condition;
        logic [6:0]         score;
        logic [10:0]        time_in_seconds;
    } snapshot_t;

endpackage

// File: rtl/uart_state_streamer_if.sv
// Byte handshake between the state streamer and the UART transmitter.
//   tx_data  : byte offered to the transmitter
//   tx_valid : tx_data is valid
//   tx_ready : transmitter takes the byte this cycle
// master = streamer side, slave = transmitter side.
interface uart_state_streamer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/state_frame_mux.sv
// Combinational selector returning frame byte sel_i of a latched snapshot.
//   snap_i   : latched game-state snapshot
//   sel_i    : frame byte index (0..68; anything else yields 8'h00)
//   byte_c_o : selected byte (combinational)
module state_frame_mux
    import sudoku_uart_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
) (
    input  snapshot_t        snap_i,
    input  logic [IDX_W-1:0] sel_i,
    output logic [7:0]       byte_c_o
);

    logic [8*BOARD_BYTES-1:0] board_pad;
    logic [8*COLOR_BYTES-1:0] color_pad;
    logic [7:0]               board_bytes [BOARD_BYTES];
    logic [7:0]               color_bytes [COLOR_BYTES];

    // Pad the last partial byte with zeros so both fields split into whole bytes, MSB first.
    always_comb begin
        board_pad = {snap_i.full_board, 4'h0};
        color_pad = {snap_i.colors, 6'b0};
    end

    always_comb begin
        for (int i = 0; i < BOARD_BYTES; i++) begin
            board_bytes[i] = board_pad[8*(BOARD_BYTES-i)-1 -: 8];
        end
    end

    always_comb begin
        for (int i = 0; i < COLOR_BYTES; i++) begin
            color_bytes[i] = color_pad[8*(COLOR_BYTES-i)-1 -: 8];
        end
    end

    // Header fields, then board region, then color region.
    always_comb begin
        byte_c_o = 8'h00;
        if (sel_i >= IDX_W'(COLOR_IDX)) begin
            if (sel_i <= IDX_W'(COLOR_IDX + COLOR_BYTES - 1)) begin
                byte_c_o = color_bytes[5'(sel_i - IDX_W'(COLOR_IDX))];
            end
        end else if (sel_i >= IDX_W'(BOARD_IDX)) begin
            byte_c_o = board_bytes[6'(sel_i - IDX_W'(BOARD_IDX))];
        end else begin
            case (sel_i)
                IDX_W'(HDR_IDX):     byte_c_o = SYNC_BYTE;
                IDX_W'(HDR_IDX + 1): byte_c_o = {snap_i.current_state, snap_i.game_dificulty,
                                                 snap_i.errors, snap_i.victory_condition, 1'b0};
                IDX_W'(HDR_IDX + 2): byte_c_o = snap_i.position;
                IDX_W'(HDR_IDX + 3): byte_c_o = {4'h0, snap_i.selected_number};
                IDX_W'(HDR_IDX + 4): byte_c_o = {1'b0, snap_i.score};
                IDX_W'(HDR_IDX + 5): byte_c_o = {5'b0, snap_i.time_in_seconds[10:8]};
                IDX_W'(HDR_IDX + 6): byte_c_o = snap_i.time_in_seconds[7:0];
                default:             byte_c_o = 8'h00;
            endcase
        end
    end

endmodule

// File: rtl/uart_state_streamer.sv
// Streams one coherent snapshot of the sudoku game state as a fixed byte
// frame over a valid/ready byte interface towards the UART transmitter.
//   clk, rst          : clock, synchronous active-high reset
//   start             : frame request, honoured only while idle
//   current_state .. time_in_seconds : game-state fields latched on start
//   tx                : byte handshake (master side)
//   busy              : frame in progress
//   done              : one-cycle pulse after the last byte is accepted
// Build option STREAMER_CHECKSUM_EN appends byte 69 = XOR of bytes 1..68.
// After the done cycle begins, start is ignored for MIN_GAP cycles (the done
// cycle being the first of them).
module uart_state_streamer
    import sudoku_uart_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE = SYNC_DEFAULT,
    parameter int unsigned MIN_GAP   = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [2:0]                current_state,
    input  logic                      game_dificulty,
    input  logic [BOARD_W-1:0]        full_board,
    input  logic [COLOR_W-1:0]        colors,
    input  logic [7:0]                position,
    input  logic [1:0]                errors,
    input  logic [3:0]                selected_number,
    input  logic                      victory_condition,
    input  logic [6:0]                score,
    input  logic [10:0]               time_in_seconds,
    uart_state_streamer_if.master     tx,
    output logic                      busy,
    output logic                      done
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       gap_q, gap_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             load_c;
    snapshot_t        snap_q, snap_in_c;
    logic [IDX_W-1:0] next_idx_c;
    logic [7:0]       next_byte_c;
`ifdef STREAMER_CHECKSUM_EN
    logic [7:0]       acc_q, acc_d;
`endif

    always_comb begin
        snap_in_c.current_state     = current_state;
        snap_in_c.game_dificulty    = game_dificulty;
        snap_in_c.full_board        = full_board;
        snap_in_c.colors            = colors;
        snap_in_c.position          = position;
        snap_in_c.errors            = errors;
        snap_in_c.selected_number   = selected_number;
        snap_in_c.victory_condition = victory_condition;
        snap_in_c.score             = score;
        snap_in_c.time_in_seconds   = time_in_seconds;
    end

    // Prefetch the byte following the current one so tx_data can stay registered.
    assign next_idx_c = idx_q + IDX_W'(1);

    state_frame_mux #(.SYNC_BYTE(SYNC_BYTE)) u_frame_mux (
        .snap_i   (snap_q),
        .sel_i    (next_idx_c),
        .byte_c_o (next_byte_c)
    );

    // Snapshot is pure datapath; it is only consumed after a load.
    always_ff @(posedge clk) begin
        if (load_c) begin
            snap_q <= snap_in_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            gap_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef STREAMER_CHECKSUM_EN
            acc_q      <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef STREAMER_CHECKSUM_EN
            acc_q      <= acc_d;
`endif
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        gap_d      = gap_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        load_c     = 1'b0;
`ifdef STREAMER_CHECKSUM_EN
        acc_d      = acc_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load_c     = 1'b1;
                    state_d    = ST_SEND;
                    idx_d      = '0;
                    tx_valid_d = 1'b1;
                    busy_d     = 1'b1;
                    tx_data_d  = SYNC_BYTE;
`ifdef STREAMER_CHECKSUM_EN
                    acc_d      = 8'h00;
`endif
                end
            end
            ST_SEND: begin
                if (tx_valid_q && tx.tx_ready) begin
`ifdef STREAMER_CHECKSUM_EN
                    // Sync byte is excluded from the checksum.
                    if (idx_q != IDX_W'(HDR_IDX)) begin
                        acc_d = acc_q ^ tx_data_q;
                    end
`endif
                    if (idx_q == IDX_W'(LAST_IDX)) begin
                        tx_valid_d = 1'b0;
                        tx_data_d  = 8'h00;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        idx_d      = '0;
                        gap_d      = 8'h00;
                        state_d    = (MIN_GAP == 0) ? ST_IDLE : ST_GAP;
                    end else begin
                        idx_d     = next_idx_c;
                        tx_data_d = next_byte_c;
`ifdef STREAMER_CHECKSUM_EN
                        // Fold in the byte leaving now, which acc_q does not yet hold.
                        if (idx_q == IDX_W'(DATA_LAST_IDX)) begin
                            tx_data_d = acc_q ^ tx_data_q;
                        end
`endif
                    end
                end
            end
            ST_GAP: begin
                if (gap_q == 8'(MIN_GAP - 1)) begin
                    gap_d   = 8'h00;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign tx.tx_data  = tx_data_q;
    assign tx.tx_valid = tx_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_uart_state_streamer.sv
// Bench for uart_state_streamer: two instances (MIN_GAP=4 and MIN_GAP=0)
// share all inputs; a frame-level reference model predicts every output of
// both instances each cycle, and a few literal expectations pin the model.
module tb_uart_state_streamer;

`ifdef STREAMER_CHECKSUM_EN
    localparam int FLEN = 70;
`else
    localparam int FLEN = 69;
`endif

    logic         clk = 1'b0;
    logic         rst, start, rdy;
    logic [2:0]   cs;
    logic         dif, vic;
    logic [323:0] board;
    logic [161:0] colors;
    logic [7:0]   pos;
    logic [1:0]   err;
    logic [3:0]   sel;
    logic [6:0]   score;
    logic [10:0]  tsec;
    logic         busy_g, done_g, busy_0, done_0;

    uart_state_streamer_if if_g ();
    uart_state_streamer_if if_0 ();
    assign if_g.tx_ready = rdy;
    assign if_0.tx_ready = rdy;

    uart_state_streamer #(.MIN_GAP(4)) dut_g (
        .clk(clk), .rst(rst), .start(start), .current_state(cs), .game_dificulty(dif),
        .full_board(board), .colors(colors), .position(pos), .errors(err),
        .selected_number(sel), .victory_condition(vic), .score(score),
        .time_in_seconds(tsec), .tx(if_g), .busy(busy_g), .done(done_g));

    uart_state_streamer #(.MIN_GAP(0)) dut_0 (
        .clk(clk), .rst(rst), .start(start), .current_state(cs), .game_dificulty(dif),
        .full_board(board), .colors(colors), .position(pos), .errors(err),
        .selected_number(sel), .victory_condition(vic), .score(score),
        .time_in_seconds(tsec), .tx(if_0), .busy(busy_0), .done(done_0));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state, index 0 = dut_g, 1 = dut_0.
    bit         m_send [2];
    int         m_idx  [2];
    int         m_gap  [2];
    bit         m_done [2];
    logic [7:0] m_frame [2][FLEN];
    logic [7:0] cur  [FLEN];
    logic [7:0] expf [FLEN];
    logic [7:0] rx_q [$];
    int         done_cnt_g = 0;
    int         busy_cyc_g = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Frame built straight from the byte-layout rules using shifts of the full fields.
    task build_frame;
        logic [323:0] b;
        logic [161:0] c;
        logic [7:0]   x;
        cur[0] = 8'hA5;
        cur[1] = {cs, dif, err, vic, 1'b0};
        cur[2] = pos;
        cur[3] = {4'h0, sel};
        cur[4] = {1'b0, score};
        cur[5] = {5'b0, tsec[10:8]};
        cur[6] = tsec[7:0];
        for (int k = 7; k <= 46; k++) begin
            b = board >> (316 - 8 * (k - 7));
            cur[k] = b[7:0];
        end
        cur[47] = {board[3:0], 4'h0};
        for (int j = 48; j <= 67; j++) begin
            c = colors >> (154 - 8 * (j - 48));
            cur[j] = c[7:0];
        end
        cur[68] = {colors[1:0], 6'b0};
        x = 8'h00;
        for (int k = 1; k <= 68; k++) x = x ^ cur[k];
        if (FLEN == 70) cur[FLEN-1] = x;
    endtask

    task automatic model_step(input int i, input int mgap, input bit r, input bit s, input bit rd);
        if (r) begin
            m_send[i] = 1'b0; m_idx[i] = 0; m_gap[i] = 0; m_done[i] = 1'b0;
        end else begin
            m_done[i] = 1'b0;
            if (m_send[i]) begin
                if (rd) begin
                    m_idx[i]++;
                    if (m_idx[i] == FLEN) begin
                        m_send[i] = 1'b0; m_idx[i] = 0; m_done[i] = 1'b1; m_gap[i] = mgap;
                    end
                end
            end else if (m_gap[i] > 0) begin
                m_gap[i]--;
            end else if (s) begin
                for (int k = 0; k < FLEN; k++) m_frame[i][k] = cur[k];
                m_send[i] = 1'b1; m_idx[i] = 0;
            end
        end
    endtask

    // Compare process: update model on the edge, check both instances 1ns later.
    bit r_s, s_s, rd_s;
    logic [7:0] exp_d;
    always @(posedge clk) begin
        r_s = rst; s_s = start; rd_s = rdy;
        if (!r_s && rd_s && if_g.tx_valid === 1'b1) rx_q.push_back(if_g.tx_data);
        if (s_s) build_frame();
        model_step(0, 4, r_s, s_s, rd_s);
        model_step(1, 0, r_s, s_s, rd_s);
        #1;
        exp_d = m_send[0] ? m_frame[0][m_idx[0]] : 8'h00;
        chk("txv_g",  32'(if_g.tx_valid), 32'(m_send[0]));
        chk("busy_g", 32'(busy_g),        32'(m_send[0]));
        chk("done_g", 32'(done_g),        32'(m_done[0]));
        chk("txd_g",  32'(if_g.tx_data),  32'(exp_d));
        exp_d = m_send[1] ? m_frame[1][m_idx[1]] : 8'h00;
        chk("txv_0",  32'(if_0.tx_valid), 32'(m_send[1]));
        chk("busy_0", 32'(busy_0),        32'(m_send[1]));
        chk("done_0", 32'(done_0),        32'(m_done[1]));
        chk("txd_0",  32'(if_0.tx_data),  32'(exp_d));
        if (done_g === 1'b1) done_cnt_g++;
        if (busy_g === 1'b1) busy_cyc_g++;
    end

    task randomize_fields;
        cs = 3'($urandom); dif = 1'($urandom); vic = 1'($urandom);
        pos = 8'($urandom); err = 2'($urandom); sel = 4'($urandom);
        score = 7'($urandom); tsec = 11'($urandom);
        for (int w = 0; w < 11; w++) board = (board << 32) | 324'($urandom);
        for (int w = 0; w < 6; w++) colors = (colors << 32) | 162'($urandom);
    endtask

    task snap_expected;
        build_frame();
        for (int k = 0; k < FLEN; k++) expf[k] = cur[k];
    endtask

    task begin_frame;
        rx_q.delete();
        done_cnt_g = 0;
        busy_cyc_g = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int max, input bit rand_rdy);
        int n = 0;
        while (done_g !== 1'b1 && n < max) begin
            if (rand_rdy) rdy = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(done_g), 32'd1);
    endtask

    task automatic check_rx(input string nm);
        int bad = 0;
        chk({nm, "_len"}, 32'(rx_q.size()), 32'(FLEN));
        if (rx_q.size() == FLEN) begin
            for (int k = 0; k < FLEN; k++) if (rx_q[k] !== expf[k]) bad++;
        end else begin
            bad = FLEN;
        end
        chk({nm, "_bytes_bad"}, 32'(bad), 32'd0);
    endtask

    task automatic idle_cycles(input int n);
        rdy = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [7:0] lit [9];
        logic [7:0] x;
        int phase;
        int n;
        lit = '{8'hA5, 8'h58, 8'h58, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h96};
        rst = 1'b1; start = 1'b1; rdy = 1'b0;
        cs = '0; dif = 0; vic = 0; pos = '0; err = '0; sel = '0; score = '0; tsec = '0;
        board = '0; colors = '0;

        // Reset held with start asserted.
        repeat (3) begin
            @(negedge clk);
            chk("rst_txv",  32'(if_g.tx_valid), 32'd0);
            chk("rst_busy", 32'(busy_g),        32'd0);
            chk("rst_done", 32'(done_g),        32'd0);
            chk("rst_txd",  32'(if_g.tx_data),  32'd0);
        end
        rst = 1'b0; start = 1'b0;
        idle_cycles(2);

        // Nominal frame.
        cs = 3'b010; dif = 1'b1; err = 2'd2; vic = 1'b0; pos = 8'h58; sel = 4'd3;
        score = 7'd0; tsec = 11'd0;
        board = {40'h0196380954, 272'h0, 12'h170};
        for (int w = 0; w < 6; w++) colors = (colors << 32) | 162'($urandom);
        snap_expected();
        rdy = 1'b1;
        begin_frame();
        wait_done("nom_done", 200, 1'b0);
        @(negedge clk);
        check_rx("nom");
        for (int k = 0; k < 9; k++) chk($sformatf("nom_lit%0d", k), 32'(rx_q[k]), 32'(lit[k]));
        chk("nom_lit47", 32'(rx_q[47]), 32'h00);
        chk("nom_lit46", 32'(rx_q[46]), 32'h17);
        chk("nom_done_cnt", 32'(done_cnt_g), 32'd1);
`ifdef STREAMER_CHECKSUM_EN
        x = 8'h00;
        for (int k = 1; k <= 68; k++) x = x ^ rx_q[k];
        chk("cksum", 32'(rx_q[69]), 32'(x));
`endif
        idle_cycles(8);

        // Backpressure: ready low, low, high for every byte.
        randomize_fields();
        snap_expected();
        rdy = 1'b0;
        begin_frame();
        phase = 0; n = 0;
        while (done_g !== 1'b1 && n < 1000) begin
            if (if_g.tx_valid === 1'b1) begin
                rdy = (phase == 2);
                phase = (phase + 1) % 3;
            end else begin
                rdy = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        chk("bp_done", 32'(done_g), 32'd1);
        @(negedge clk);
        check_rx("bp");
        chk("bp_busy_cycles", 32'(busy_cyc_g), 32'(3 * FLEN));
        idle_cycles(8);

        // Coherence: fields change and start pulses mid-frame.
        randomize_fields();
        snap_expected();
        begin_frame();
        repeat (15) begin
            rdy = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        randomize_fields();
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_done("coh_done", 1000, 1'b1);
        @(negedge clk);
        check_rx("coh");
        idle_cycles(10);
        chk("coh_no_restart", 32'(busy_g), 32'd0);
        chk("coh_done_cnt", 32'(done_cnt_g), 32'd1);

        // Gap window: start in the done cycle and inside the gap is ignored.
        randomize_fields();
        rdy = 1'b1;
        begin_frame();
        wait_done("gap_done", 200, 1'b0);
        start = 1'b1; @(negedge clk);
        start = 1'b0; @(negedge clk);
        start = 1'b1; @(negedge clk);
        start = 1'b0;
        chk("gap_ignored", 32'(busy_g), 32'd0);
        @(negedge clk);
        start = 1'b1; @(negedge clk);
        start = 1'b0;
        chk("gap_accepted", 32'(busy_g), 32'd1);
        n = 0;
        while ((busy_g !== 1'b0 || busy_0 !== 1'b0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("gap_drain", 32'(busy_g | busy_0), 32'd0);
        idle_cycles(8);

        // Reset while byte 20 is presented.
        randomize_fields();
        rdy = 1'b1;
        begin_frame();
        n = 0;
        while (rx_q.size() < 20 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("mid_reached20", 32'(rx_q.size()), 32'd20);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_txv", 32'(if_g.tx_valid), 32'd0);
        idle_cycles(4);
        chk("mid_no_done", 32'(done_cnt_g), 32'd0);
        randomize_fields();
        snap_expected();
        begin_frame();
        wait_done("mid_new_done", 200, 1'b0);
        @(negedge clk);
        check_rx("mid_new");
        idle_cycles(6);

        // Randomized frames with random backpressure.
        for (int f = 0; f < 6; f++) begin
            randomize_fields();
            snap_expected();
            begin_frame();
            wait_done($sformatf("rnd%0d_done", f), 1000, 1'b1);
            @(negedge clk);
            check_rx($sformatf("rnd%0d", f));
            idle_cycles(5 + $urandom_range(0, 4));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
